fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_pkg.sv | 5 +
 rtl/fetch_controller_if.sv | 29 ++
 rtl/fetch_controller.sv | 131 +++++++++++++
 tb/tb_fetch_controller.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared CPU constants used by the fetch controller and its interface.
package fetch_controller_pkg;
    localparam int XLEN             = 32;
    localparam int INSTR_ALIGN_BITS = 2;
endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory request/response channel plus the buffered-instruction
// channel towards decode.
interface fetch_controller_if;
    import fetch_controller_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// Single-outstanding-request instruction fetch FSM with a one-entry
// instruction buffer; the PC itself lives in the parent and is steered here.
//
// state | meaning
// ------+-----------------------------------------------------------
// BOOT  | first cycle after reset, no strobes
// REQ   | imem_req high until granted
// WAIT  | request accepted, waiting for read data
// HOLD  | instruction buffered, offered to decode
// FLUSH | redirected while a request is in flight; drop its response
// HALT  | misaligned redirect trapped; only reset leaves
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            pc_count,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_value,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault,
    fetch_controller_if.master bus
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FLUSH = 3'd4,
        HALT  = 3'd5
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            capture;
    logic            misaligned;
    logic            redirect_take;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;

    assign misaligned    = MISALIGN_TRAP && (redirect_pc[INSTR_ALIGN_BITS-1:0] != '0);
    assign redirect_take = redirect && (state != HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc;
            end
        end
    end

    always_comb begin
        next_state      = state;
        capture         = 1'b0;
        pc_count        = 1'b0;
        pc_load         = 1'b0;
        fetch_fault     = 1'b0;
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;

        case (state)
            BOOT: next_state = REQ;
            REQ: begin
                bus.imem_req = 1'b1;
                if (bus.imem_gnt) next_state = WAIT;
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    capture    = 1'b1;
                    pc_count   = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                bus.instr_valid = 1'b1;
                if (bus.instr_ready) next_state = REQ;
            end
            FLUSH: begin
                if (bus.imem_rvalid) next_state = REQ;
            end
            HALT: next_state = HALT;
            default: next_state = BOOT;
        endcase

        // Redirect overrides every handshake; an in-flight response is
        // either consumed this cycle or left for FLUSH to swallow.
        if (redirect_take) begin
            capture  = 1'b0;
            pc_count = 1'b0;
            if (misaligned) begin
                fetch_fault = 1'b1;
                next_state  = HALT;
            end else begin
                pc_load = 1'b1;
                case (state)
                    REQ:     next_state = bus.imem_gnt    ? FLUSH : REQ;
                    WAIT:    next_state = bus.imem_rvalid ? REQ   : FLUSH;
                    FLUSH:   next_state = bus.imem_rvalid ? REQ   : FLUSH;
                    default: next_state = REQ;
                endcase
            end
        end

        if (reset) begin
            next_state      = BOOT;
            capture         = 1'b0;
            pc_count        = 1'b0;
            pc_load         = 1'b0;
            fetch_fault     = 1'b0;
            bus.imem_req    = 1'b0;
            bus.instr_valid = 1'b0;
        end
    end

    assign bus.imem_addr = reset ? '0 : pc;
    assign pc_value      = reset ? '0 : redirect_pc;
    assign bus.instr     = instr_q;
    assign bus.instr_pc  = instr_pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scenario bench for fetch_controller with a PC model, a one-cycle memory
// responder and a scoreboard of instructions expected at decode.
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_count, pc_load, fetch_fault;
    logic [31:0] pc_value;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        auto_mem, man_gnt, man_rvalid, ready;
    logic [31:0] man_rdata;
    logic        pend;
    logic [31:0] pend_addr;

    int checks = 0;
    int errors = 0;
    int n_count, n_load, n_fault, n_accept;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    fetch_controller_if bus();

    fetch_controller #(.MISALIGN_TRAP(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_count    (pc_count),
        .pc_load     (pc_load),
        .pc_value    (pc_value),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_fault (fetch_fault),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0013 ^ {a[23:0], 8'h00};
    endfunction

    assign bus.imem_gnt    = auto_mem ? bus.imem_req : man_gnt;
    assign bus.imem_rvalid = auto_mem ? pend : man_rvalid;
    assign bus.imem_rdata  = auto_mem ? mem_word(pend_addr) : man_rdata;
    assign bus.instr_ready = ready;

    // Parent-side PC register and single-cycle memory
    always @(posedge clk) begin
        if (reset) begin
            pc        <= 32'h0;
            pend      <= 1'b0;
            pend_addr <= 32'h0;
        end else begin
            if (pc_load)       pc <= pc_value;
            else if (pc_count) pc <= pc + 32'd4;
            pend <= bus.imem_req && bus.imem_gnt;
            if (bus.imem_req && bus.imem_gnt) pend_addr <= bus.imem_addr;
        end
    end

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (pc_count)    n_count++;
            if (pc_load)     n_load++;
            if (fetch_fault) n_fault++;
            if (pc_count || pc_load) begin
                checks++;
                if (pc_count && pc_load) begin
                    errors++;
                    $display("FAIL pc_strobe_excl: pc_count=%b pc_load=%b, required not both", pc_count, pc_load);
                end
            end
            if (bus.instr_valid && ready) begin
                n_accept++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: instr=%h pc=%h, required no delivery", bus.instr, bus.instr_pc);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.instr !== mon_e.data || bus.instr_pc !== mon_e.addr) begin
                        errors++;
                        $display("FAIL sb_instr: got %h@%h, required %h@%h", bus.instr, bus.instr_pc, mon_e.data, mon_e.addr);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        auto_mem = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = 32'h0; ready = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_count = 0; n_load = 0; n_fault = 0; n_accept = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; auto_mem = 1'b1; ready = 1'b1;
        man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        v = {27'h0, bus.imem_req, pc_count, pc_load, fetch_fault, bus.instr_valid};
        checks++;
        if (v !== 32'h0 || bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.imem_addr !== 32'h0 || pc_value !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: strobes=%h instr=%h instr_pc=%h addr=%h, required all 0", v, bus.instr, bus.instr_pc, bus.imem_addr);
        end
        do_reset();
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL boot_no_req: imem_req=%b, required 0", bus.imem_req);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL first_req: req=%b addr=%h, required 1/00000000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_basic();
        int reqc[$];
        int cyc;
        do_reset();
        auto_mem = 1'b1; ready = 1'b1;
        sb.push_back('{32'h0, 32'h0000_0013});
        sb.push_back('{32'h4, mem_word(32'h4)});
        sb.push_back('{32'h8, mem_word(32'h8)});
        cyc = 0;
        while (n_accept < 3 && cyc < 40) begin
            @(negedge clk); #1;
            if (bus.imem_req) reqc.push_back(cyc);
            cyc++;
            #2;
        end
        checks++;
        if (n_accept < 3) begin
            errors++; $display("FAIL basic_timeout: accepted=%0d, required 3", n_accept);
        end
        checks++;
        if (reqc.size() < 3 || reqc[1] - reqc[0] != 3 || reqc[2] - reqc[1] != 3) begin
            errors++; $display("FAIL basic_cadence: req cycles=%p, required spacing 3", reqc);
        end
        checks++;
        if (n_count != 3 || sb.size() != 0) begin
            errors++; $display("FAIL basic_count: pc_count=%0d left=%0d, required 3/0", n_count, sb.size());
        end
    endtask

    task automatic test_stall();
        int cyc;
        do_reset();
        auto_mem = 1'b1; ready = 1'b0;
        sb.push_back('{32'h0, 32'h0000_0013});
        cyc = 0;
        while (bus.instr_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk); #1; cyc++;
        end
        checks++;
        if (bus.instr_valid !== 1'b1) begin
            errors++; $display("FAIL stall_timeout: instr_valid=%b, required 1", bus.instr_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({bus.instr_valid, bus.imem_req, pc_count} !== 3'b100 || bus.instr !== 32'h13 || bus.instr_pc !== 32'h0) begin
                errors++;
                $display("FAIL stall_hold: valid/req/cnt=%b%b%b instr=%h pc=%h, required 100/00000013/00000000",
                         bus.instr_valid, bus.imem_req, pc_count, bus.instr, bus.instr_pc);
            end
        end
        #2;
        checks++;
        if (n_count != 1) begin
            errors++; $display("FAIL stall_count: pc_count=%0d, required 1", n_count);
        end
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        #3;
        checks++;
        if (n_accept != 1 || sb.size() != 0) begin
            errors++; $display("FAIL stall_release: accepted=%0d left=%0d, required 1/0", n_accept, sb.size());
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        @(negedge clk); man_gnt = 1'b1; #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL rw_req: req=%b addr=%h, required 1/00000000", bus.imem_req, bus.imem_addr);
        end
        @(negedge clk); man_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; #1;
        checks++;
        if ({pc_load, pc_count} !== 2'b10 || pc_value !== 32'h100) begin
            errors++; $display("FAIL rw_load: load/cnt=%b%b value=%h, required 10/00000100", pc_load, pc_count, pc_value);
        end
        @(negedge clk); redirect = 1'b0; #1;
        checks++;
        if ({bus.imem_req, pc_load} !== 2'b00) begin
            errors++; $display("FAIL rw_flush: req/load=%b%b, required 00", bus.imem_req, pc_load);
        end
        @(negedge clk); man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF; #1;
        checks++;
        if ({bus.imem_req, pc_count, pc_load} !== 3'b000) begin
            errors++; $display("FAIL rw_discard: req/cnt/load=%b%b%b, required 000", bus.imem_req, pc_count, pc_load);
        end
        @(negedge clk); man_rvalid = 1'b0; man_gnt = 1'b1; ready = 1'b1; #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL rw_refetch: req=%b addr=%h valid=%b, required 1/00000100/0", bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        sb.push_back('{32'h100, 32'h0010_0093});
        @(negedge clk); man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0010_0093; #1;
        checks++;
        if (pc_count !== 1'b1) begin
            errors++; $display("FAIL rw_capture: pc_count=%b, required 1", pc_count);
        end
        @(negedge clk); man_rvalid = 1'b0; #3;
        checks++;
        if (n_load != 1 || n_accept != 1 || sb.size() != 0) begin
            errors++; $display("FAIL rw_summary: loads=%0d accepted=%0d left=%0d, required 1/1/0", n_load, n_accept, sb.size());
        end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        ready = 1'b1;
        @(negedge clk); man_gnt = 1'b1;
        @(negedge clk); man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
        redirect = 1'b1; redirect_pc = 32'h200; #1;
        checks++;
        if ({pc_load, pc_count} !== 2'b10) begin
            errors++; $display("FAIL rr_strobes: load/cnt=%b%b, required 10", pc_load, pc_count);
        end
        @(negedge clk); man_rvalid = 1'b0; redirect = 1'b0; #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200 || bus.instr_valid !== 1'b0 || bus.instr !== 32'h0) begin
            errors++; $display("FAIL rr_next: req=%b addr=%h valid=%b instr=%h, required 1/00000200/0/00000000",
                               bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr);
        end
    endtask

    task automatic test_redirect_hold();
        int cyc;
        do_reset();
        auto_mem = 1'b1; ready = 1'b0;
        cyc = 0;
        while (bus.instr_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk); #1; cyc++;
        end
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h40; #1;
        checks++;
        if ({pc_load, bus.instr_valid} !== 2'b11 || bus.instr !== 32'h13) begin
            errors++; $display("FAIL rh_load: load/valid=%b%b instr=%h, required 11/00000013", pc_load, bus.instr_valid, bus.instr);
        end
        @(negedge clk); redirect = 1'b0; #1;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
            errors++; $display("FAIL rh_drop: valid=%b req=%b addr=%h, required 0/1/00000040", bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
        sb.push_back('{32'h40, mem_word(32'h40)});
        ready = 1'b1;
        cyc = 0;
        while (n_accept < 1 && cyc < 20) begin
            @(negedge clk); #3; cyc++;
        end
        checks++;
        if (n_accept != 1 || sb.size() != 0) begin
            errors++; $display("FAIL rh_refetch: accepted=%0d left=%0d, required 1/0", n_accept, sb.size());
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        @(negedge clk); man_gnt = 1'b1;
        @(negedge clk); man_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h102; #1;
        checks++;
        if ({fetch_fault, pc_load} !== 2'b10) begin
            errors++; $display("FAIL mis_fault: fault/load=%b%b, required 10", fetch_fault, pc_load);
        end
        @(negedge clk); redirect = 1'b0; #1;
        checks++;
        if ({fetch_fault, bus.imem_req, bus.instr_valid} !== 3'b000) begin
            errors++; $display("FAIL mis_pulse: fault/req/valid=%b%b%b, required 000", fetch_fault, bus.imem_req, bus.instr_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            redirect = 1'b1; redirect_pc = 32'h300; man_gnt = 1'b1; man_rvalid = 1'b1; man_rdata = 32'h1234_5678; ready = 1'b1;
            #1;
            checks++;
            if ({bus.imem_req, bus.instr_valid, pc_count, pc_load, fetch_fault} !== 5'b00000) begin
                errors++; $display("FAIL mis_halt: req/valid/cnt/load/fault=%b%b%b%b%b, required 00000",
                                   bus.imem_req, bus.instr_valid, pc_count, pc_load, fetch_fault);
            end
        end
        #2;
        checks++;
        if (n_fault != 1 || pc !== 32'h0) begin
            errors++; $display("FAIL mis_once: faults=%0d pc=%h, required 1/00000000", n_fault, pc);
        end
        do_reset();
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL mis_boot: req=%b, required 0", bus.imem_req);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL mis_resume: req=%b addr=%h, required 1/00000000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [4:0] v;
        do_reset();
        ready = 1'b1;
        @(negedge clk); man_gnt = 1'b1;
        @(negedge clk); man_gnt = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hFEED_F00D; #1;
        v = {bus.imem_req, bus.instr_valid, pc_count, pc_load, fetch_fault};
        checks++;
        if (v !== 5'b0 || bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL riw_boot: strobes=%b instr=%h instr_pc=%h addr=%h, required 0", v, bus.instr, bus.instr_pc, bus.imem_addr);
        end
        @(negedge clk); man_rvalid = 1'b0; #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
            errors++; $display("FAIL riw_req: req=%b valid=%b instr=%h instr_pc=%h, required 1/0/00000000/00000000",
                               bus.imem_req, bus.instr_valid, bus.instr, bus.instr_pc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_reset();
        auto_mem = 1'b1;
        for (int i = 0; i < 6; i++) sb.push_back('{32'(4 * i), mem_word(32'(4 * i))});
        cyc = 0;
        while (n_accept < 6 && cyc < 200) begin
            @(negedge clk);
            ready = 1'($urandom_range(0, 1));
            #3;
            cyc++;
        end
        checks++;
        if (n_accept != 6 || sb.size() != 0 || n_count != 6) begin
            errors++; $display("FAIL b2b: accepted=%0d left=%0d pc_count=%0d, required 6/0/6", n_accept, sb.size(), n_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_hold();
        test_misaligned();
        test_reset_in_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
